// File: rtl/clock_reset_sequencer_if.sv
// Control/status bundle of the clock/reset sequencer: lock flags and requests in,
// generator reset, domain resets, qualified valid and loss count out.
interface clock_reset_sequencer_if #(
  parameter int NUM_LOCKS   = 1,
  parameter int NUM_DOMAINS = 4,
  parameter int CNT_W       = 8
);
  logic [NUM_LOCKS-1:0]   i_locked;
  logic                   i_soft_reset;
  logic                   i_clear_count;
  logic                   o_pll_reset;
  logic [NUM_DOMAINS-1:0] o_domain_reset;
  logic                   o_valid;
  logic [CNT_W-1:0]       o_loss_count;

  modport master (
    output i_locked, i_soft_reset, i_clear_count,
    input  o_pll_reset, o_domain_reset, o_valid, o_loss_count
  );

  modport slave (
    input  i_locked, i_soft_reset, i_clear_count,
    output o_pll_reset, o_domain_reset, o_valid, o_loss_count
  );
endinterface

// File: rtl/clock_reset_sequencer.sv
// Supervises clock-generator lock, pulses the generator reset, and releases the
// per-domain resets in a staggered order once lock has been stable.
module clock_reset_sequencer #(
  parameter int NUM_LOCKS      = 1,
  parameter int NUM_DOMAINS    = 4,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int STABLE_CYCLES  = 256,
  parameter int STAGGER_CYCLES = 8,
  parameter int CNT_W          = 8
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  clock_reset_sequencer_if.slave bus
);

  localparam int REL_CYCLES = NUM_DOMAINS * STAGGER_CYCLES;
  localparam int MAX_A      = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
  localparam int MAX_B      = (REL_CYCLES > PLL_RST_CYCLES) ? REL_CYCLES : PLL_RST_CYCLES;
  localparam int CNT_MAX    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  // One extra code so RELEASE can sit at REL_CYCLES for its final cycle.
  localparam int CW         = $clog2(CNT_MAX + 1);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t PLL_LAST     = cnt_t'(PLL_RST_CYCLES - 1);
  localparam cnt_t TIMEOUT_LAST = cnt_t'(LOCK_TIMEOUT - 1);
  localparam cnt_t STABLE_LAST  = cnt_t'(STABLE_CYCLES - 1);
  localparam cnt_t REL_LAST     = cnt_t'(REL_CYCLES);

  typedef enum logic [2:0] {
    ST_PLL_RST,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RELEASE,
    ST_RUN
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [NUM_LOCKS-1:0]   lock_sync_p0, lock_sync_p1;
  logic                   lock_s;
  state_t                 state, state_nx;
  cnt_t                   cnt, cnt_nx;
  logic                   loss_evt;
  logic                   pll_reset_q, pll_reset_nx;
  logic [NUM_DOMAINS-1:0] domain_reset_q, domain_reset_nx;
  logic                   valid_q, valid_nx;
  logic [CNT_W-1:0]       loss_count_q, loss_count_nx;

  // Stage p0 -> p1: two-flop synchronizer on each asynchronous lock flag
  always_ff @(posedge i_clock) begin
    lock_sync_p0 <= bus.i_locked;
    lock_sync_p1 <= lock_sync_p0;
  end

  assign lock_s = &lock_sync_p1;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state          <= ST_PLL_RST;
      cnt            <= '0;
      pll_reset_q    <= 1'b1;
      domain_reset_q <= '1;
      valid_q        <= 1'b0;
      loss_count_q   <= '0;
    end else begin
      state          <= state_nx;
      cnt            <= cnt_nx;
      pll_reset_q    <= pll_reset_nx;
      domain_reset_q <= domain_reset_nx;
      valid_q        <= valid_nx;
      loss_count_q   <= loss_count_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = '0;
    loss_evt = 1'b0;
    case (state)
      ST_PLL_RST: begin
        if (cnt == PLL_LAST) state_nx = ST_WAIT_LOCK;
        else                 cnt_nx   = cnt + 1'b1;
      end
      ST_WAIT_LOCK: begin
        if (lock_s)                    state_nx = ST_STABLE;
        else if (cnt == TIMEOUT_LAST)  state_nx = ST_PLL_RST;
        else                           cnt_nx   = cnt + 1'b1;
      end
      ST_STABLE: begin
        if (!lock_s)                  state_nx = ST_WAIT_LOCK;
        else if (cnt == STABLE_LAST)  state_nx = ST_RELEASE;
        else                          cnt_nx   = cnt + 1'b1;
      end
      ST_RELEASE, ST_RUN: begin
        // Lock loss wins over a same-cycle soft reset; soft reset restarts RELEASE at 0.
        if (!lock_s) begin
          state_nx = ST_WAIT_LOCK;
          loss_evt = 1'b1;
        end else if (bus.i_soft_reset) begin
          state_nx = ST_RELEASE;
        end else if (state == ST_RELEASE) begin
          if (cnt == REL_LAST) state_nx = ST_RUN;
          else                 cnt_nx   = cnt + 1'b1;
        end
      end
      default: state_nx = ST_PLL_RST;
    endcase
  end

  // Outputs are registered from the next state/count so they track the state exactly.
  always_comb begin
    pll_reset_nx    = (state_nx == ST_PLL_RST);
    valid_nx        = (state_nx == ST_RUN);
    domain_reset_nx = '1;
    if (state_nx == ST_RUN) begin
      domain_reset_nx = '0;
    end else if (state_nx == ST_RELEASE) begin
      for (int k = 0; k < NUM_DOMAINS; k++)
        domain_reset_nx[k] = (cnt_nx < cnt_t'((k + 1) * STAGGER_CYCLES));
    end
    if (bus.i_clear_count)  loss_count_nx = '0;
    else if (loss_evt)      loss_count_nx = sat_inc(loss_count_q);
    else                    loss_count_nx = loss_count_q;
  end

  assign bus.o_pll_reset    = pll_reset_q;
  assign bus.o_domain_reset = domain_reset_q;
  assign bus.o_valid        = valid_q;
  assign bus.o_loss_count   = loss_count_q;

endmodule

// File: tb/tb_clock_reset_sequencer.sv
// Bench for clock_reset_sequencer: directed scenarios plus random lock/soft/clear
// traffic, every cycle compared against a timeline model of the sequencer.
module tb_clock_reset_sequencer;

  localparam int NL = 2;
  localparam int ND = 3;
  localparam int P  = 16;
  localparam int T  = 20;
  localparam int S  = 10;
  localparam int G  = 4;
  localparam int CW = 2;
  localparam int LOSS_MAX = (1 << CW) - 1;

  localparam int M_PLL = 0, M_WAIT = 1, M_STB = 2, M_REL = 3, M_RUN = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  clock_reset_sequencer_if #(.NUM_LOCKS(NL), .NUM_DOMAINS(ND), .CNT_W(CW)) bus ();

  clock_reset_sequencer #(
    .NUM_LOCKS(NL), .NUM_DOMAINS(ND), .PLL_RST_CYCLES(P), .LOCK_TIMEOUT(T),
    .STABLE_CYCLES(S), .STAGGER_CYCLES(G), .CNT_W(CW)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: current phase, cycles already spent in it, loss count, lock history.
  int m_phase = M_PLL;
  int m_t     = 0;
  int m_loss  = 0;
  logic [NL-1:0] hist1 = '0, hist2 = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [ND-1:0] exp_dom();
    logic [ND-1:0] r;
    for (int k = 0; k < ND; k++)
      r[k] = !(m_phase == M_RUN || (m_phase == M_REL && m_t >= (k + 1) * G));
    return r;
  endfunction

  task automatic model_step();
    logic ls;
    logic loss_evt;
    ls    = &hist2;
    hist2 = hist1;
    hist1 = bus.i_locked;
    if (rst) begin
      m_phase = M_PLL; m_t = 0; m_loss = 0;
      return;
    end
    loss_evt = (m_phase == M_REL || m_phase == M_RUN) && !ls;
    case (m_phase)
      M_PLL:  begin m_t++; if (m_t == P) begin m_phase = M_WAIT; m_t = 0; end end
      M_WAIT: begin
        if (ls) begin m_phase = M_STB; m_t = 0; end
        else begin m_t++; if (m_t == T) begin m_phase = M_PLL; m_t = 0; end end
      end
      M_STB: begin
        if (!ls) begin m_phase = M_WAIT; m_t = 0; end
        else begin m_t++; if (m_t == S) begin m_phase = M_REL; m_t = 0; end end
      end
      default: begin
        if (!ls)                   begin m_phase = M_WAIT; m_t = 0; end
        else if (bus.i_soft_reset) begin m_phase = M_REL;  m_t = 0; end
        else if (m_phase == M_REL) begin
          if (m_t == ND * G) begin m_phase = M_RUN; m_t = 0; end
          else m_t++;
        end
      end
    endcase
    if (bus.i_clear_count)                 m_loss = 0;
    else if (loss_evt && m_loss < LOSS_MAX) m_loss++;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("pll_reset", 32'(bus.o_pll_reset), 32'(m_phase == M_PLL));
    chk("domain_reset", 32'(bus.o_domain_reset), 32'(exp_dom()));
    chk("valid", 32'(bus.o_valid), 32'(m_phase == M_RUN));
    chk("loss_count", 32'(bus.o_loss_count), 32'(m_loss));
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    cycles(n);
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (!bus.o_valid && n < budget) begin cycle(); n++; end
    chk(tag, 32'(bus.o_valid), 32'd1);
  endtask

  task automatic wait_model(input string tag, input int ph, input int t, input int budget);
    int n = 0;
    while (!(m_phase == ph && m_t == t) && n < budget) begin cycle(); n++; end
    chk(tag, 32'(m_phase == ph && m_t == t), 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int pll_hi, lat, r, len;
    logic [NL-1:0] mask;
    bus.i_locked      = '1;
    bus.i_soft_reset  = 1'b0;
    bus.i_clear_count = 1'b0;
    @(negedge clk);
    do_reset(4);

    // Power-up with lock present: PLL reset length and time to valid
    pll_hi = 0; lat = -1;
    for (int i = 0; i < 200 && lat < 0; i++) begin
      if (bus.o_pll_reset) pll_hi++;
      if (bus.o_valid) lat = i;
      else cycle();
    end
    chk("pll_len", 32'(pll_hi), 32'd16);
    chk("valid_latency", 32'(lat), 32'd40);
    chk("loss_after_boot", 32'(bus.o_loss_count), 32'd0);

    // Lock never present: periodic PLL reset pulses, soft reset ignored in WAIT_LOCK
    bus.i_locked = '0;
    do_reset(3);
    pll_hi = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.o_pll_reset) pll_hi++;
      bus.i_soft_reset = (i == 20);
      cycle();
    end
    bus.i_soft_reset = 1'b0;
    chk("pll_repulse", 32'(pll_hi), 32'd48);

    // One-cycle glitch in the middle of STABLE
    bus.i_locked = '1;
    do_reset(3);
    wait_model("reach_stable", M_STB, 4, 200);
    bus.i_locked = 2'b10;
    cycle();
    bus.i_locked = '1;
    wait_valid("valid_after_glitch", 200);
    chk("loss_after_glitch", 32'(bus.o_loss_count), 32'd0);

    // Five lock losses in RUN with a saturating 2-bit counter
    for (int n = 0; n < 5; n++) begin
      bus.i_locked = 2'b01;
      cycles(2);
      chk("valid_held_2edges", 32'(bus.o_valid), 32'd1);
      cycle();
      chk("loss_valid", 32'(bus.o_valid), 32'd0);
      chk("loss_domains", 32'(bus.o_domain_reset), 32'h7);
      chk("loss_count_step", 32'(bus.o_loss_count), 32'((n + 1 > 3) ? 3 : n + 1));
      bus.i_locked = '1;
      wait_valid("relock_valid", 200);
    end
    chk("loss_saturated", 32'(bus.o_loss_count), 32'd3);

    // Soft reset in RUN
    bus.i_soft_reset = 1'b1;
    cycle();
    bus.i_soft_reset = 1'b0;
    chk("soft_domains", 32'(bus.o_domain_reset), 32'h7);
    chk("soft_no_pll", 32'(bus.o_pll_reset), 32'd0);
    wait_valid("valid_after_soft", 100);

    // Clear in the same cycle the loss is counted
    bus.i_locked = 2'b00;
    cycles(2);
    bus.i_clear_count = 1'b1;
    cycle();
    bus.i_clear_count = 1'b0;
    chk("clear_beats_inc", 32'(bus.o_loss_count), 32'd0);
    chk("clear_loss_domains", 32'(bus.o_domain_reset), 32'h7);

    // Reset in the middle of RELEASE
    bus.i_locked = '1;
    wait_model("reach_release", M_REL, 6, 200);
    rst = 1'b1;
    cycle();
    chk("midrst_pll", 32'(bus.o_pll_reset), 32'd1);
    chk("midrst_domains", 32'(bus.o_domain_reset), 32'h7);
    chk("midrst_valid", 32'(bus.o_valid), 32'd0);
    rst = 1'b0;
    wait_valid("valid_after_midrst", 200);

    // Random traffic
    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 19);
      if (r < 7) begin
        cycles($urandom_range(1, 40));
      end else if (r < 12) begin
        mask = NL'($urandom_range(1, (1 << NL) - 1));
        len  = $urandom_range(1, 30);
        bus.i_locked = ~mask;
        cycles(len);
        bus.i_locked = '1;
      end else if (r < 15) begin
        bus.i_soft_reset = 1'b1;
        cycle();
        bus.i_soft_reset = 1'b0;
      end else if (r < 17) begin
        bus.i_clear_count = 1'b1;
        cycle();
        bus.i_clear_count = 1'b0;
      end else if (r < 19) begin
        bus.i_soft_reset  = 1'b1;
        bus.i_clear_count = 1'b1;
        cycle();
        bus.i_soft_reset  = 1'b0;
        bus.i_clear_count = 1'b0;
      end else begin
        do_reset($urandom_range(1, 3));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
